// File: rtl/irq_pend_encoder_if.sv
// Event/mask/handshake bundle for irq_pend_encoder.
// master drives events, mask writes and ready; slave is the encoder.
interface irq_pend_encoder_if;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       ready;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       valid;
    logic [2:0] pos;

    modport master (
        output req, mask_wr, mask_data, ready,
        input  mask, pending, valid, pos
    );

    modport slave (
        input  req, mask_wr, mask_data, ready,
        output mask, pending, valid, pos
    );
endinterface

// File: rtl/irq_pend_encoder.sv
// Pending-event latch with mask and 8-to-3 priority select offered over valid/ready.
// Optional sticky overflow flags are enabled by defining IRQ_PEND_OVF_EN.
module encoder_8to3 (
    input  logic [7:0] in,
    output logic [2:0] out
);
    // Ascending scan: the last set bit seen (highest index) wins.
    always_comb begin
        out = 3'd0;
        for (int i = 0; i < 8; i++)
            if (in[i]) out = 3'(i);
    end
endmodule

module irq_pend_encoder #(
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_pend_encoder_if.slave    bus
`ifdef IRQ_PEND_OVF_EN
    ,
    input  logic                 ovf_clr,
    output logic [7:0]           ovf
`endif
);
    logic [7:0] req_d;
    logic [7:0] pend_q;
    logic [7:0] mask_q;
    logic       valid_q;
    logic [2:0] pos_q;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] vis;
    logic [2:0] enc;
    logic       accept;

    assign rise   = bus.req & ~req_d;
    assign accept = valid_q & bus.ready;
    assign clr    = accept ? (8'h01 << pos_q) : 8'h00;
    assign vis    = pend_q & mask_q;

    encoder_8to3 u_enc (
        .in  (vis),
        .out (enc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_d   <= 8'h00;
            pend_q  <= 8'h00;
            mask_q  <= MASK_RST;
            valid_q <= 1'b0;
            pos_q   <= 3'd0;
        end else begin
            req_d  <= bus.req;
            // A rise on the bit being cleared keeps it set.
            pend_q <= (pend_q & ~clr) | rise;
            if (bus.mask_wr) mask_q <= bus.mask_data;
            if (accept) begin
                valid_q <= 1'b0;
            end else if (!valid_q) begin
                valid_q <= |vis;
                pos_q   <= enc;
            end
        end
    end

`ifdef IRQ_PEND_OVF_EN
    logic [7:0] ovf_set;
    logic [7:0] ovf_q;

    assign ovf_set = rise & pend_q & ~clr;

    always_ff @(posedge clk) begin
        if (rst)          ovf_q <= 8'h00;
        else if (ovf_clr) ovf_q <= ovf_set;
        else              ovf_q <= ovf_q | ovf_set;
    end

    assign ovf = ovf_q;
`endif

    assign bus.mask    = mask_q;
    assign bus.pending = pend_q;
    assign bus.valid   = valid_q;
    assign bus.pos     = pos_q;
endmodule

// File: tb/tb_irq_pend_encoder.sv
// Directed and randomized bench for irq_pend_encoder against a cycle model of the event rules.
// Build with IRQ_PEND_OVF_EN defined to also cover the overflow flags.
module tb_irq_pend_encoder;
    localparam logic [7:0] MASK_RST = 8'hFF;

    logic clk;
    logic rst;
    irq_pend_encoder_if bus();
`ifdef IRQ_PEND_OVF_EN
    logic       ovf_clr;
    logic [7:0] ovf;
`endif

    irq_pend_encoder #(.MASK_RST(MASK_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IRQ_PEND_OVF_EN
        ,
        .ovf_clr (ovf_clr),
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state, advanced once per clock edge by step().
    logic [7:0] m_reqd, m_pend, m_mask, m_ovf;
    logic       m_valid;
    logic [2:0] m_pos;

    task automatic model_update();
        logic [7:0] r, c, vis;
        logic       oc;
`ifdef IRQ_PEND_OVF_EN
        oc = ovf_clr;
`else
        oc = 1'b0;
`endif
        if (rst) begin
            m_reqd = 8'h00; m_pend = 8'h00; m_mask = MASK_RST;
            m_valid = 1'b0; m_pos = 3'd0; m_ovf = 8'h00;
        end else begin
            r   = bus.req & ~m_reqd;
            c   = (m_valid && bus.ready) ? 8'(2 ** m_pos) : 8'h00;
            vis = m_pend & m_mask;
            m_ovf = (oc ? 8'h00 : m_ovf) | (r & m_pend & ~c);
            if (m_valid && bus.ready) begin
                m_valid = 1'b0;
            end else if (!m_valid) begin
                m_valid = (vis != 8'h00);
                // highest set bit = floor(log2(vis))
                m_pos = (vis != 8'h00) ? 3'($clog2(int'(vis) + 1) - 1) : 3'd0;
            end
            m_pend = (m_pend & ~c) | r;
            if (bus.mask_wr) m_mask = bus.mask_data;
            m_reqd = bus.req;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; bus.req = 8'h00; bus.mask_wr = 1'b0; bus.mask_data = 8'h00; bus.ready = 1'b0;
`ifdef IRQ_PEND_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; bus.req = 8'hA5; bus.ready = 1'b1;
        step(); step();
        rst = 1'b0; bus.req = 8'h00; bus.ready = 1'b0;
        checks++;
        if ({bus.mask, bus.pending, bus.valid, bus.pos} !== {MASK_RST, 8'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset mask/pend/valid/pos got %h/%h/%b/%0d want %h/00/0/0",
                     bus.mask, bus.pending, bus.valid, bus.pos, MASK_RST);
        end
`ifdef IRQ_PEND_OVF_EN
        checks++;
        if (ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf got %h want 00", ovf); end
`endif
    endtask

    task automatic test_hold();
        bus.req = 8'h04; step(); bus.req = 8'h00;
        checks++;
        if ({bus.pending, bus.valid} !== {8'h04, 1'b0}) begin
            errors++; $display("FAIL hold_latch pend/valid got %h/%b want 04/0", bus.pending, bus.valid);
        end
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bus.pending, bus.valid, bus.pos} !== {8'h04, 1'b1, 3'd2}) begin
                errors++;
                $display("FAIL hold cyc %0d pend/valid/pos got %h/%b/%0d want 04/1/2", i, bus.pending, bus.valid, bus.pos);
            end
            step();
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
        checks++;
        if ({bus.pending, bus.valid} !== {8'h00, 1'b0}) begin
            errors++; $display("FAIL hold_accept pend/valid got %h/%b want 00/0", bus.pending, bus.valid);
        end
    endtask

    task automatic test_accept();
        bus.req = 8'h81; step(); bus.req = 8'h00; step();
        checks++;
        if ({bus.valid, bus.pos} !== {1'b1, 3'd7}) begin
            errors++; $display("FAIL acc_first valid/pos got %b/%0d want 1/7", bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
        checks++;
        if ({bus.pending, bus.valid} !== {8'h01, 1'b0}) begin
            errors++; $display("FAIL acc_bubble pend/valid got %h/%b want 01/0", bus.pending, bus.valid);
        end
        step();
        checks++;
        if ({bus.valid, bus.pos} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL acc_second valid/pos got %b/%0d want 1/0", bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); step(); bus.ready = 1'b0;
        checks++;
        if ({bus.pending, bus.valid} !== {8'h00, 1'b0}) begin
            errors++; $display("FAIL acc_empty pend/valid got %h/%b want 00/0", bus.pending, bus.valid);
        end
    endtask

    task automatic test_no_preempt();
        bus.req = 8'h08; step(); bus.req = 8'h00; step();
        bus.req = 8'h40; step(); bus.req = 8'h00; step();
        checks++;
        if ({bus.pending, bus.valid, bus.pos} !== {8'h48, 1'b1, 3'd3}) begin
            errors++; $display("FAIL preempt pend/valid/pos got %h/%b/%0d want 48/1/3", bus.pending, bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
        checks++;
        if (bus.valid !== 1'b0) begin errors++; $display("FAIL preempt_bubble valid got %b want 0", bus.valid); end
        step();
        checks++;
        if ({bus.valid, bus.pos} !== {1'b1, 3'd6}) begin
            errors++; $display("FAIL preempt_next valid/pos got %b/%0d want 1/6", bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
    endtask

    task automatic test_mask();
        bus.mask_wr = 1'b1; bus.mask_data = 8'h0F; step(); bus.mask_wr = 1'b0;
        bus.req = 8'h82; step(); bus.req = 8'h00; step();
        checks++;
        if ({bus.mask, bus.pending, bus.valid, bus.pos} !== {8'h0F, 8'h82, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL mask_sel mask/pend/valid/pos got %h/%h/%b/%0d want 0f/82/1/1", bus.mask, bus.pending, bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0; step(); step();
        checks++;
        if ({bus.pending, bus.valid} !== {8'h80, 1'b0}) begin
            errors++; $display("FAIL mask_hidden pend/valid got %h/%b want 80/0", bus.pending, bus.valid);
        end
        bus.mask_wr = 1'b1; bus.mask_data = 8'hFF; step(); bus.mask_wr = 1'b0; step();
        checks++;
        if ({bus.valid, bus.pos} !== {1'b1, 3'd7}) begin
            errors++; $display("FAIL mask_open valid/pos got %b/%0d want 1/7", bus.valid, bus.pos);
        end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        bus.req = 8'h20; step(); bus.req = 8'h00; step();
        bus.req = 8'h20; bus.ready = 1'b1; step(); bus.req = 8'h00; bus.ready = 1'b0;
        checks++;
        if ({bus.pending, bus.valid} !== {8'h20, 1'b0}) begin
            errors++; $display("FAIL same_cyc pend/valid got %h/%b want 20/0", bus.pending, bus.valid);
        end
        step();
        checks++;
        if ({bus.valid, bus.pos} !== {1'b1, 3'd5}) begin
            errors++; $display("FAIL same_cyc_ret valid/pos got %b/%0d want 1/5", bus.valid, bus.pos);
        end
`ifdef IRQ_PEND_OVF_EN
        checks++;
        if (ovf !== 8'h00) begin errors++; $display("FAIL same_cyc_ovf got %h want 00", ovf); end
`endif
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
    endtask

`ifdef IRQ_PEND_OVF_EN
    task automatic test_ovf();
        bus.req = 8'h10; step(); bus.req = 8'h00; step();
        bus.req = 8'h10; step(); bus.req = 8'h00;
        checks++;
        if (ovf !== 8'h10) begin errors++; $display("FAIL ovf_set got %h want 10", ovf); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        checks++;
        if (ovf !== 8'h00) begin errors++; $display("FAIL ovf_clr got %h want 00", ovf); end
        bus.ready = 1'b1; step(); bus.ready = 1'b0;
    endtask
`endif

    task automatic test_rst_mid();
        bus.mask_wr = 1'b1; bus.mask_data = 8'h3C; step(); bus.mask_wr = 1'b0;
        bus.req = 8'h0C; step(); bus.req = 8'h00; step();
        checks++;
        if (bus.valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre valid got %b want 1", bus.valid); end
        rst = 1'b1; bus.ready = 1'b1; step(); rst = 1'b0; bus.ready = 1'b0;
        checks++;
        if ({bus.mask, bus.pending, bus.valid, bus.pos} !== {MASK_RST, 8'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL rst_mid mask/pend/valid/pos got %h/%h/%b/%0d want %h/00/0/0",
                     bus.mask, bus.pending, bus.valid, bus.pos, MASK_RST);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.req       = 8'($urandom) & 8'($urandom) & 8'($urandom);
            bus.ready     = ($urandom_range(0, 2) != 0);
            bus.mask_wr   = ($urandom_range(0, 15) == 0);
            bus.mask_data = 8'($urandom);
`ifdef IRQ_PEND_OVF_EN
            ovf_clr = ($urandom_range(0, 9) == 0);
`endif
            step();
            checks++;
            if ({bus.mask, bus.pending, bus.valid, bus.pos} !== {m_mask, m_pend, m_valid, m_pos}) begin
                errors++;
                $display("FAIL rand cyc %0d mask/pend/valid/pos got %h/%h/%b/%0d want %h/%h/%b/%0d",
                         i, bus.mask, bus.pending, bus.valid, bus.pos, m_mask, m_pend, m_valid, m_pos);
            end
`ifdef IRQ_PEND_OVF_EN
            checks++;
            if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %h want %h", i, ovf, m_ovf); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        m_reqd = 8'h00; m_pend = 8'h00; m_mask = MASK_RST; m_valid = 1'b0; m_pos = 3'd0; m_ovf = 8'h00;
        test_reset();
        test_hold();
        test_accept();
        test_no_preempt();
        test_mask();
        test_same_cycle();
`ifdef IRQ_PEND_OVF_EN
        test_ovf();
`endif
        test_random();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_pend_encoder.md
Name: irq_pend_encoder

Overview:
- Collects eight event lines into a pending register and presents the highest-priority pending, unmasked event as a 3-bit index.
- The index is offered over a valid/ready handshake. The pending bit clears when the consumer accepts it.
- Sits directly upstream of the combinational 8-to-3 priority stage. It instantiates encoder_8to3 on the masked pending vector: bit 7 highest, bit 0 lowest.

Parameters:
- MASK_RST, 8'hFF, reset value of the mask register (1 = line enabled).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  8  event lines, assumed synchronous to clk; rising edges are latched.
- mask_wr  input  1  load mask_data into the mask register this cycle.
- mask_data  input  8  new mask value.
- ready  input  1  consumer accepts pos when high with valid.
- mask  output  8  current mask register.
- pending  output  8  current pending register (unmasked view).
- valid  output  1  pos holds an event index.
- pos  output  3  index of the presented event.

Behaviour:
- Reset (rst high at a clock edge): req_d=0, pending=0, mask=MASK_RST, valid=0, pos=0. rst overrides every other input in that cycle, including a handshake in progress.
- Edge detect:
  - rise = req & ~req_d; req_d <= req every cycle.
  - A line held high produces a single event. A line must go low for at least one cycle before it re-arms.
- Pending update each cycle:
  - pending <= (pending & ~clr) | rise.
  - clr is a one-hot of pos when valid && ready, otherwise 0.
  - A rise on the bit being cleared in the same cycle wins: the bit stays set.
  - Rise edges latch regardless of mask. Masking only hides a bit from selection.
- Output register:
  - If valid && ready: valid <= 0. This gives a mandatory one-cycle bubble after every accept.
  - Else if valid && !ready: valid and pos hold unchanged. A higher-priority arrival or a mask change does not alter or withdraw the presented index.
  - Else (valid low): valid <= |(pending & mask); pos <= encoder_8to3(pending & mask).
- Latency:
  - req rises before edge n → pending bit set at edge n → valid/pos at edge n+1, provided the output is idle.
  - The back-to-back accept rate is one event per 2 cycles.
- Mask:
  - mask <= mask_data at an edge where mask_wr=1.
  - The new mask affects selection from the next cycle.
  - mask=0 with nonzero pending keeps valid low; the events stay pending.
- Boundaries:
  - An event on a bit that is already pending is absorbed, with no count kept.
  - All eight bits pending: service order is 7,6,...,0, provided no new edges arrive.
  - ready high while valid low has no effect.

Optional Feature:
- Macro IRQ_PEND_OVF_EN.
- When defined, adds two ports:
  - ovf_clr  input  1
  - ovf  output  8
- ovf[i] sets when rise[i]=1 while pending[i]=1 and the bit is not being cleared that same cycle.
- ovf is sticky. It clears to 0 on an edge with ovf_clr=1; a set in the same cycle wins. Reset value is 0.
- When not defined, neither port exists and there is no overflow logic. All other behaviour is identical.

Test Plan:
- Reset, then req=8'b0000_0100 pulsed 1 cycle, ready=0 → pending=8'h04 one edge later, then valid=1, pos=2. Both hold for 10 cycles; pending stays 8'h04.
- pending=8'h81 presented (pos=7), then assert ready 1 cycle → valid=0 next cycle, pending=8'h01. The cycle after: valid=1, pos=0. After a second accept, pending=0 and valid stays 0.
- valid=1, pos=3 held with ready=0, then req bit 6 rises → pos stays 3, pending=8'h48. After accept, the bubble cycle, then pos=6.
- mask_wr=1, mask_data=8'h0F, then events on bits 7 and 1 → pos=1 only; pending=8'h82 after accept clears to 8'h80, and valid stays 0. Then write mask=8'hFF → pos=7.
- Accept bit 5 in the same cycle req[5] rises again → pending[5] remains 1, valid returns with pos=5 after the bubble. With IRQ_PEND_OVF_EN, ovf stays 8'h00.
- With IRQ_PEND_OVF_EN: two rises on bit 4 without an accept → ovf=8'h10. Pulse ovf_clr → ovf=8'h00. Assert rst mid-handshake (valid=1) → all outputs at reset values on the next edge.
